aes_inv_keysched_seq: RTL and testbench
=======================================

Name: aes_inv_keysched_seq

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Takes the round-10 key and streams round keys 10, 9, ... 0 over a valid/ready handshake.
- Uses a single byte-serial forward S-box and an accumulation register, so each backward step takes 4 substitution cycles.
- The decrypt round controller consumes keys in the order they are produced; the full schedule does not need to be stored.

Parameters:
- NROUNDS, 10, number of backward steps (AES-128 only; AES-192/256 are out of scope).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  latch last_key and begin; sampled in IDLE only.
- last_key  in  128  round-10 key; word w0 = [127:96], w3 = [31:0].
- key_out  out  128  current round key; held stable while key_valid && !key_ready.
- round_out  out  4  round index of key_out (10 down to 0).
- key_valid  out  1  key_out/round_out valid.
- key_ready  in  1  consumer accepts when key_valid && key_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset values: key_out=0, round_out=0, key_valid=0, busy=0, done=0, FSM=IDLE, byte counter=0, accumulator=0.
- FSM states: IDLE, PRESENT, SUB.
- IDLE:
  - On start=1, register last_key into key_out, set round_out=10, go to PRESENT.
  - key_valid rises the cycle after start.
- PRESENT:
  - key_valid=1.
  - On handshake with round_out>0, go to SUB with cnt=0.
  - On handshake with round_out==0, go to IDLE and pulse done=1 for one cycle.
- SUB (cnt 0..3, one S-box byte per cycle, key_valid=0):
  - Let current key = w4..w7. Compute combinationally: w3=w7^w6, w2=w6^w5, w1=w5^w4.
  - S-box input per cnt: 0 -> w3[31:24], 1 -> w3[7:0], 2 -> w3[15:8], 3 -> w3[23:16].
  - S-box output per cnt goes to accumulator byte: 0 -> T[7:0], 1 -> T[15:8], 2 -> T[23:16], 3 -> T[31:24].
  - This yields T = SubWord(RotWord(w3)).
  - At the cnt=3 edge: key_out <= {w4 ^ T ^ {RCON[round_out],24'h0}, w1, w2, w3}; round_out <= round_out-1; go to PRESENT.
- S-box: the forward aes_sbox (the inverse S-box is not used).
- RCON indexed by the round being undone: 1..10 -> 01,02,04,08,10,20,40,80,1B,36.
- Latency:
  - start to first key_valid: 1 cycle.
  - Accept of round r to key_valid for round r-1: 5 cycles (4 SUB + 1).
  - Full schedule with key_ready tied high: 1 + 10*5 + 1 cycles to done.
- Boundary conditions:
  - start while busy: ignored; last_key is not re-latched.
  - key_ready low in PRESENT: hold key_out, round_out and key_valid indefinitely.
  - key_ready during SUB: no effect.
  - start in the same cycle as the done pulse: ignored, since the FSM is no longer in IDLE-sampled state until the next cycle; start is accepted from the cycle after.
  - Reset mid-SUB or mid-PRESENT: immediate return to reset values; no partial key is ever presented.
  - round_out never underflows; round 0 is terminal.

Decomposition:
- Shared package aes_pkg:
  - RCON byte array [1:10].
  - FSM state enum {IDLE, PRESENT, SUB}.
  - AES128_ROUNDS=10.
- Reuse the existing aes_sbox as the sole sub-module.
- The byte accumulator stays inline; it mirrors the forward accumulation register but is indexed by cnt.

Test Plan:
- FIPS-197 key 2b7e1516..., last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 -> round 10 = d014f9a8...; round 9 = ac7766f319fadc2128d12941575c006e (5 cycles later); round 0 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses once.
- last_key=b4ef5bcb3e92e21123e951cf6f8f188e (zero-key schedule) -> round 0 key_out = 128'h0; round_out sequence 10..0 with no gaps.
- Backpressure: key_ready=0 for 7 cycles at round 6 -> key_out/round_out stable and key_valid held; after accept, round 5 appears exactly 5 cycles later.
- start pulsed at round 4 with a different last_key -> ignored; sequence continues to the correct round 0.
- reset asserted during SUB cnt=2 -> key_valid=0, busy=0, round_out=0 immediately; next start restarts cleanly from round 10.
- Cycle count with key_ready=1: start at cycle 0 -> done at cycle 52; busy high in cycles 1..51.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key schedule.
// Contents: round count, datapath widths, FSM state enum, RCON table and lookup helper.
package aes_pkg;

    localparam int unsigned AES128_ROUNDS = 10;
    localparam int unsigned KEY_W         = 128;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned RND_W         = 4;
    localparam int unsigned CNT_W         = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SUB     = 2'd2
    } ks_state_e;

    // Round constants, indexed by the round being undone.
    localparam logic [BYTE_W-1:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Out-of-range rounds return zero so the lookup is total.
    function automatic logic [BYTE_W-1:0] rcon_byte(input logic [RND_W-1:0] rnd);
        logic [BYTE_W-1:0] r;
        r = '0;
        for (int unsigned i = 1; i <= 10; i++) begin
            if (rnd == RND_W'(i)) r = RCON[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
// Ports: data_i - input byte; data_c_o - substituted byte (combinational).
module aes_sbox (
    input  logic [7:0] data_i,
    output logic [7:0] data_c_o
);

    // Row 0 of the table sits in the MSBs; byte n lives at bits [(255-n)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_idx;

    assign bit_idx  = {~data_i, 3'b000};
    assign data_c_o = SBOX_TABLE[bit_idx +: 8];

endmodule

// File: rtl/aes_inv_keysched_seq.sv
// Iterative AES-128 inverse key schedule: latches the round-10 key and streams
// round keys 10..0 over valid/ready, using one byte-serial forward S-box.
// Ports:
//   clk, reset      - clock, async active-high reset
//   start, last_key - begin a schedule from the round-10 key (IDLE only)
//   key_out         - current round key, round_out its index
//   key_valid/ready - output handshake
//   busy, done      - activity flag, one-cycle completion pulse
module aes_inv_keysched_seq
    import aes_pkg::*;
#(
    parameter int unsigned NROUNDS = AES128_ROUNDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] last_key,
    output logic [KEY_W-1:0] key_out,
    output logic [RND_W-1:0] round_out,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             busy,
    output logic             done
);

    ks_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  acc_q, acc_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  w4, w5, w6, w7;
    logic [WORD_W-1:0]  w1, w2, w3;
    logic [WORD_W-1:0]  t_word;
    logic [BYTE_W-1:0]  sbox_in;
    logic [BYTE_W-1:0]  sbox_out;

    // Previous-round words recovered by XOR-ing adjacent words of the current key.
    assign w4 = key_q[127:96];
    assign w5 = key_q[95:64];
    assign w6 = key_q[63:32];
    assign w7 = key_q[31:0];
    assign w3 = w7 ^ w6;
    assign w2 = w6 ^ w5;
    assign w1 = w5 ^ w4;

    // Byte order walks RotWord(w3) so the accumulator fills LSB first.
    always_comb begin
        sbox_in = w3[31:24];
        case (cnt_q)
            2'd0:    sbox_in = w3[31:24];
            2'd1:    sbox_in = w3[7:0];
            2'd2:    sbox_in = w3[15:8];
            default: sbox_in = w3[23:16];
        endcase
    end

    aes_sbox u_sbox (
        .data_i   (sbox_in),
        .data_c_o (sbox_out)
    );

    // Final byte comes straight from the S-box on the cnt=3 cycle.
    assign t_word = {sbox_out, acc_q[23:0]};

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is not an accepting cycle.
                if (start && !done_q) begin
                    key_d   = last_key;
                    round_d = RND_W'(NROUNDS);
                    state_d = PRESENT;
                end
            end

            PRESENT: begin
                if (key_ready) begin
                    if (round_q != '0) begin
                        cnt_d   = '0;
                        state_d = SUB;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            SUB: begin
                case (cnt_q)
                    2'd0:    acc_d[7:0]   = sbox_out;
                    2'd1:    acc_d[15:8]  = sbox_out;
                    2'd2:    acc_d[23:16] = sbox_out;
                    default: acc_d[31:24] = sbox_out;
                endcase
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    key_d   = {w4 ^ t_word ^ {rcon_byte(round_q), 24'h000000}, w1, w2, w3};
                    round_d = round_q - RND_W'(1);
                    state_d = PRESENT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == PRESENT);
        busy_d  = (state_d != IDLE);
    end

    assign key_out   = key_q;
    assign round_out = round_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_keysched_seq.sv
// Directed self-checking bench for aes_inv_keysched_seq.
module tb_aes_inv_keysched_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] last_key;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;
    bit busy_bad;

    logic [127:0] fips [0:10];
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    aes_inv_keysched_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .last_key  (last_key),
        .key_out   (key_out),
        .round_out (round_out),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Steps negedges until key_valid, returning the number of cycles taken.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!key_valid && !busy) busy_bad = 1'b1;
        end while (!key_valid && n < 40);
        if (!key_valid) check("valid_timeout", 128'(key_valid), 128'd1);
    endtask

    // Runs one full schedule from a negedge with the FSM idle; returns at the done negedge.
    task automatic run_sched(input logic [127:0] lk, input bit is_fips,
                             input int stall_r, input int start_r, output int cycles);
        int  n;
        bit  hold_bad;
        start     = 1'b1;
        last_key  = lk;
        key_ready = 1'b1;
        busy_bad  = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        check("first_valid", 128'(key_valid), 128'd1);
        check("r10_round", 128'(round_out), 128'd10);
        check("r10_key", key_out, lk);
        for (int r = 9; r >= 0; r--) begin
            if (r + 1 == stall_r) begin
                key_ready = 1'b0;
                hold_bad  = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    cycles++;
                    if (!key_valid || round_out !== 4'(stall_r) || key_out !== fips[stall_r])
                        hold_bad = 1'b1;
                end
                check("bp_hold", 128'(hold_bad), 128'd0);
                key_ready = 1'b1;
            end
            if (r + 1 == start_r) begin
                start    = 1'b1;
                last_key = ~lk;
            end
            wait_valid(n);
            start  = 1'b0;
            cycles += n;
            check("step_latency", 128'(n), 128'd5);
            check("round_seq", 128'(round_out), 128'(r));
            if (is_fips) check("fips_key", key_out, fips[r]);
        end
        if (!is_fips) check("zero_r0", key_out, 128'd0);
        check("busy_during", 128'(busy_bad), 128'd0);
        @(negedge clk);
        cycles++;
        check("done_pulse", 128'(done), 128'd1);
        check("busy_after", 128'(busy), 128'd0);
    endtask

    initial begin
        int cyc;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset     = 1'b1;
        start     = 1'b0;
        key_ready = 1'b0;
        last_key  = '0;
        #2;
        check("rst_key", key_out, 128'd0);
        check("rst_round", 128'(round_out), 128'd0);
        check("rst_valid", 128'(key_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // FIPS-197 schedule with key_ready high throughout.
        run_sched(fips[10], 1'b1, -1, -1, cyc);
        check("cycles_to_done", 128'(cyc), 128'd52);

        // start during the done cycle is ignored, accepted one cycle later.
        start    = 1'b1;
        last_key = ZERO_R10;
        @(negedge clk);
        check("start_on_done_ignored", 128'(key_valid), 128'd0);
        check("done_one_cycle", 128'(done), 128'd0);
        run_sched(ZERO_R10, 1'b0, -1, -1, cyc);
        @(negedge clk);
        check("done_low_after", 128'(done), 128'd0);

        // Backpressure at round 6 and a stray start at round 4.
        run_sched(fips[10], 1'b1, 6, 4, cyc);
        check("bp_cycles", 128'(cyc), 128'd59);
        @(negedge clk);

        // Reset in the middle of SUB (cnt=2).
        start     = 1'b1;
        last_key  = fips[10];
        key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_in_sub", 128'(key_valid), 128'd0);
        reset = 1'b1;
        #1;
        check("midsub_valid", 128'(key_valid), 128'd0);
        check("midsub_busy", 128'(busy), 128'd0);
        check("midsub_round", 128'(round_out), 128'd0);
        check("midsub_key", key_out, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_sched(fips[10], 1'b1, -1, -1, cyc);
        check("restart_cycles", 128'(cyc), 128'd52);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
